// File: rtl/arm_alu_reg_if.sv
// Operand/flag bus between the execute-stage operand muxes and the registered ALU.
// The master drives operands and samples results; the slave is the ALU itself.
interface arm_alu_reg_if;
   logic [31:0] i_op1;
   logic [31:0] i_op2;
   logic [3:0]  i_nzcv;
   logic [3:0]  i_opcode;
   logic        i_shift_carry;
   logic [31:0] o_result;
   logic [3:0]  o_nzcv;

   modport master (
      output i_op1, i_op2, i_nzcv, i_opcode, i_shift_carry,
      input  o_result, o_nzcv
   );

   modport slave (
      input  i_op1, i_op2, i_nzcv, i_opcode, i_shift_carry,
      output o_result, o_nzcv
   );
endinterface

// File: rtl/arm_alu_reg.sv
// ARMv4 data-processing ALU with registered result and NZCV flags.
// No handshake: one operation is captured on every rising edge.
module arm_alu_reg (
   input  logic          i_clk,
   input  logic          i_rst_n,
   arm_alu_reg_if.slave  bus
);

   logic [31:0] w_a;
   logic [31:0] w_b;
   logic        w_cin;
   logic        w_arith;
   logic [32:0] w_sum;
   logic [31:0] w_result;
   logic [3:0]  w_nzcv;
   logic [31:0] r_result;
   logic [3:0]  r_nzcv;

   // Effective adder operands; subtracts feed the inverted operand.
   always_comb begin
      w_a     = bus.i_op1;
      w_b     = bus.i_op2;
      w_cin   = 1'b0;
      w_arith = 1'b0;
      case (bus.i_opcode)
         4'b0010, 4'b1010: begin
            w_b     = ~bus.i_op2;
            w_cin   = 1'b1;
            w_arith = 1'b1;
         end
         4'b0011: begin
            w_a     = bus.i_op2;
            w_b     = ~bus.i_op1;
            w_cin   = 1'b1;
            w_arith = 1'b1;
         end
         4'b0100, 4'b1011: w_arith = 1'b1;
         4'b0101: begin
            w_cin   = bus.i_nzcv[1];
            w_arith = 1'b1;
         end
         4'b0110: begin
            w_b     = ~bus.i_op2;
            w_cin   = bus.i_nzcv[1];
            w_arith = 1'b1;
         end
         4'b0111: begin
            w_a     = bus.i_op2;
            w_b     = ~bus.i_op1;
            w_cin   = bus.i_nzcv[1];
            w_arith = 1'b1;
         end
         default: ;
      endcase
   end

   assign w_sum = {1'b0, w_a} + {1'b0, w_b} + {32'd0, w_cin};

   always_comb begin
      w_result = w_sum[31:0];
      case (bus.i_opcode)
         4'b0000, 4'b1000: w_result = bus.i_op1 & bus.i_op2;
         4'b0001, 4'b1001: w_result = bus.i_op1 ^ bus.i_op2;
         4'b1100:          w_result = bus.i_op1 | bus.i_op2;
         4'b1101:          w_result = bus.i_op2;
         4'b1110:          w_result = bus.i_op1 & ~bus.i_op2;
         4'b1111:          w_result = ~bus.i_op2;
         default:          w_result = w_sum[31:0];
      endcase
   end

   // Logical ops take C from the shifter and leave V untouched.
   always_comb begin
      w_nzcv[3] = w_result[31];
      w_nzcv[2] = (w_result == 32'd0);
      w_nzcv[1] = bus.i_shift_carry;
      w_nzcv[0] = bus.i_nzcv[0];
      if (w_arith) begin
         w_nzcv[1] = w_sum[32];
         w_nzcv[0] = (w_a[31] == w_b[31]) && (w_result[31] != w_a[31]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_result <= 32'd0;
         r_nzcv   <= 4'd0;
      end else begin
         r_result <= w_result;
         r_nzcv   <= w_nzcv;
      end
   end

   assign bus.o_result = r_result;
   assign bus.o_nzcv   = r_nzcv;

endmodule

// File: tb/tb_arm_alu_reg.sv
// Directed-vector bench for arm_alu_reg with hand-computed results and flags.
module tb_arm_alu_reg;

   logic i_clk;
   logic i_rst_n;
   int   total;
   int   bad;

   arm_alu_reg_if bus ();

   arm_alu_reg dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus.slave)
   );

   initial begin
      i_clk = 1'b0;
      forever #5 i_clk = ~i_clk;
   end

   task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [3:0] nzcv, input logic sc);
      bus.i_opcode      = op;
      bus.i_op1         = a;
      bus.i_op2         = b;
      bus.i_nzcv        = nzcv;
      bus.i_shift_carry = sc;
   endtask

   task automatic check(input string tag, input logic [31:0] exp_r, input logic [3:0] exp_f);
      total++;
      assert (bus.o_result === exp_r)
      else begin
         bad++;
         $error("FAIL %s result: got %h expected %h", tag, bus.o_result, exp_r);
      end
      total++;
      assert (bus.o_nzcv === exp_f)
      else begin
         bad++;
         $error("FAIL %s nzcv: got %b expected %b", tag, bus.o_nzcv, exp_f);
      end
   endtask

   // Drive at the falling edge, capture on the rising edge, sample 1ns later.
   task automatic step(input string tag, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] nzcv, input logic sc,
                       input logic [31:0] exp_r, input logic [3:0] exp_f);
      @(negedge i_clk);
      drive(op, a, b, nzcv, sc);
      @(posedge i_clk);
      #1;
      check(tag, exp_r, exp_f);
   endtask

   logic [31:0] b2b_res [16];
   logic [3:0]  b2b_flg [16];

   initial begin
      total = 0;
      bad   = 0;
      b2b_res = '{32'h8, 32'h6, 32'h2, 32'hFFFFFFFE, 32'h16, 32'h17, 32'h2, 32'hFFFFFFFE,
                  32'h8, 32'h6, 32'h2, 32'h16, 32'hE, 32'hA, 32'h4, 32'hFFFFFFF5};
      b2b_flg = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0000, 4'b0000, 4'b0010, 4'b1000,
                  4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0010, 4'b0010, 4'b0010, 4'b1010};

      // Reset held across edges with an ADD applied.
      i_rst_n = 1'b0;
      drive(4'b0100, 32'd2, 32'd3, 4'b0000, 1'b0);
      repeat (2) @(posedge i_clk);
      #1;
      check("reset_hold", 32'd0, 4'b0000);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      check("reset_release_add", 32'd5, 4'b0000);

      step("add_ovf", 4'b0100, 32'h7FFFFFFF, 32'h1, 4'b0000, 1'b0, 32'h80000000, 4'b1001);
      step("add_wrap", 4'b0100, 32'hFFFFFFFF, 32'h1, 4'b0000, 1'b0, 32'h0, 4'b0110);
      step("sub_eq", 4'b0010, 32'd5, 32'd5, 4'b0000, 1'b0, 32'h0, 4'b0110);
      step("sub_minv", 4'b0010, 32'h80000000, 32'h1, 4'b0000, 1'b0, 32'h7FFFFFFF, 4'b0011);
      step("cmp_neg", 4'b1010, 32'd3, 32'd5, 4'b0000, 1'b0, 32'hFFFFFFFE, 4'b1000);
      step("rsb", 4'b0011, 32'd1, 32'd0, 4'b0000, 1'b0, 32'hFFFFFFFF, 4'b1000);
      step("adc", 4'b0101, 32'hFFFFFFFF, 32'd0, 4'b0010, 1'b0, 32'h0, 4'b0110);
      step("sbc", 4'b0110, 32'd5, 32'd3, 4'b0000, 1'b0, 32'h1, 4'b0010);
      step("rsc", 4'b0111, 32'd3, 32'd5, 4'b0010, 1'b0, 32'h2, 4'b0010);
      step("mvn", 4'b1111, 32'd0, 32'd0, 4'b0001, 1'b1, 32'hFFFFFFFF, 4'b1011);
      step("tst", 4'b1000, 32'hF0, 32'h0F, 4'b0000, 1'b0, 32'h0, 4'b0100);
      step("bic", 4'b1110, 32'hFF, 32'h0F, 4'b0000, 1'b0, 32'hF0, 4'b0000);

      // Inputs changed mid-cycle must not reach the outputs before the edge.
      @(negedge i_clk);
      drive(4'b1101, 32'd0, 32'h1234, 4'b1111, 1'b1);
      #1;
      check("hold_between_edges", 32'hF0, 4'b0000);

      // Every opcode back to back with op1=12, op2=10, C=1, shift carry=1.
      for (int i = 0; i < 16; i++) begin
         step($sformatf("b2b_op%0d", i), 4'(i), 32'd12, 32'd10, 4'b0010, 1'b1,
              b2b_res[i], b2b_flg[i]);
      end

      // Reset between edges clears at once and discards the in-flight op.
      @(negedge i_clk);
      drive(4'b0100, 32'd100, 32'd1, 4'b0000, 1'b0);
      #2;
      i_rst_n = 1'b0;
      #1;
      check("midstream_reset", 32'd0, 4'b0000);
      @(posedge i_clk);
      #1;
      check("reset_discard", 32'd0, 4'b0000);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(posedge i_clk);
      #1;
      check("post_reset_add", 32'd101, 4'b0000);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
